rns_int_alu: RTL and testbench

- Registered execute-stage arithmetic block for the 8-bit RISC/RNS pipeline.
- Contains an 8-bit integer ALU (add/sub, compare, shift, logical and bitwise ops, carry and compare flags).
- Contains one RNS residue lane (add/sub/mul modulo a parameterised modulus).
- The EX stage instantiates one per RNS domain; the integer path is used from domain 0 only.

---
 rtl/rns_int_alu_pkg.sv | 20 ++
 rtl/rns_mod_lane.sv | 30 +++
 rtl/rns_int_alu.sv | 67 ++++++
 tb/tb_rns_int_alu.sv | 134 +++++++++++++
 4 files changed

// File: rtl/rns_int_alu_pkg.sv
// rns_int_alu_pkg: shared widths and alu_ctrl bit positions for the execute stage
package rns_int_alu_pkg;
  localparam int DW = 8;
  localparam int CW = 14;
  localparam int MW = 9;
  localparam int ALU_ADD  = 0;
  localparam int ALU_OR   = 1;
  localparam int ALU_NOT  = 2;
  localparam int ALU_ANDB = 3;
  localparam int ALU_ORB  = 4;
  localparam int ALU_NOTB = 5;
  localparam int ALU_AND  = 6;
  localparam int ALU_CIN  = 7;
  localparam int ALU_CMPL = 8;
  localparam int ALU_JMP  = 9;
  localparam int ALU_CMP  = 10;
  localparam int ALU_SHL  = 11;
  localparam int ALU_LOB  = 12;
  localparam int ALU_RSV  = 13;
endpackage

// File: rtl/rns_mod_lane.sv
// rns_mod_lane: combinational residue add/sub/mul for one compile-time modulus
module rns_mod_lane
  import rns_int_alu_pkg::*;
#(
  parameter logic [MW-1:0] MODULUS = 9'd129
) (
  input  logic [DW-1:0] op1,
  input  logic [DW-1:0] op2,
  input  logic          mul,
  input  logic          sub,
  input  logic          add,
  output logic [DW-1:0] res
);
  localparam logic [15:0] M16 = {7'd0, MODULUS};
  localparam logic [9:0]  M10 = {1'b0, MODULUS};
  logic [15:0] a, b, prod, prod_m;
  logic [9:0]  sum, dif, sum_m, dif_m;
  always_comb begin
    a      = {8'd0, op1} % M16;
    b      = {8'd0, op2} % M16;
    prod   = a * b;
    prod_m = prod % M16;
    sum    = a[9:0] + b[9:0];
    // adding M before subtracting keeps the difference non-negative
    dif    = a[9:0] + M10 - b[9:0];
    sum_m  = sum >= M10 ? sum - M10 : sum;
    dif_m  = dif >= M10 ? dif - M10 : dif;
    res    = mul ? DW'(prod_m) : (add && sub) ? DW'(dif_m) : add ? DW'(sum_m) : '0;
  end
endmodule

// File: rtl/rns_int_alu.sv
// rns_int_alu: registered 8-bit integer ALU plus one RNS residue lane
module rns_int_alu
  import rns_int_alu_pkg::*;
#(
  parameter logic [MW-1:0] MODULUS = 9'd129
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_en,
  input  logic          rns_en,
  input  logic [DW-1:0] op1_in,
  input  logic [DW-1:0] op2_in,
  input  logic [CW-1:0] alu_ctrl,
  input  logic          mul_op,
  output logic [DW-1:0] dout,
  output logic          cout,
  output logic          comp_gt,
  output logic          comp_lt,
  output logic          comp_eq,
  output logic [DW-1:0] rns_dout
);
  logic [DW:0]   cmp_s, add_s, int_nxt;
  logic [DW-1:0] lane_res, rns_nxt;
  logic          cmp_on, ctrl_unused;
  assign ctrl_unused = ^{alu_ctrl[ALU_JMP], alu_ctrl[ALU_LOB], alu_ctrl[ALU_RSV]};
  rns_mod_lane #(.MODULUS(MODULUS)) u_lane (
    .op1(op1_in),
    .op2(op2_in),
    .mul(mul_op),
    .sub(alu_ctrl[ALU_CMPL]),
    .add(alu_ctrl[ALU_ADD]),
    .res(lane_res)
  );
  always_comb begin
    cmp_s   = {1'b0, op1_in} + {1'b0, ~op2_in} + 9'd1;
    add_s   = {1'b0, op1_in} + {1'b0, alu_ctrl[ALU_CMPL] ? ~op2_in : op2_in} + {8'd0, alu_ctrl[ALU_CIN]};
    // {cout, dout}; priority follows the order of the ternary chain
    int_nxt = !alu_en             ? '0 :
              alu_ctrl[ALU_CMP]  ? cmp_s :
              alu_ctrl[ALU_ADD]  ? add_s :
              alu_ctrl[ALU_SHL]  ? {op1_in, 1'b0} :
              alu_ctrl[ALU_AND]  ? {8'd0, |op1_in && |op2_in} :
              alu_ctrl[ALU_OR]   ? {8'd0, |op1_in || |op2_in} :
              alu_ctrl[ALU_NOT]  ? {8'd0, ~|op1_in} :
              alu_ctrl[ALU_ANDB] ? {1'b0, op1_in & op2_in} :
              alu_ctrl[ALU_ORB]  ? {1'b0, op1_in | op2_in} :
              alu_ctrl[ALU_NOTB] ? {1'b0, ~op1_in} : '0;
    cmp_on  = alu_en && alu_ctrl[ALU_CMP];
    rns_nxt = rns_en ? lane_res : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dout     <= '0;
      cout     <= 1'b0;
      comp_gt  <= 1'b0;
      comp_lt  <= 1'b0;
      comp_eq  <= 1'b0;
      rns_dout <= '0;
    end else begin
      dout     <= int_nxt[DW-1:0];
      cout     <= int_nxt[DW];
      comp_gt  <= cmp_on && op1_in > op2_in;
      comp_lt  <= cmp_on && op1_in < op2_in;
      comp_eq  <= cmp_on && op1_in == op2_in;
      rns_dout <= rns_nxt;
    end
endmodule

// File: tb/tb_rns_int_alu.sv
// tb_rns_int_alu: directed and random checks of rns_int_alu at M=129 and M=256
module tb_rns_int_alu;
  logic clk = 0, reset = 0, alu_en = 0, rns_en = 0, mul_op = 0;
  logic [7:0] op1 = 0, op2 = 0;
  logic [13:0] ctrl = 0;
  logic [7:0] dout_a, rns_a, dout_b, rns_b;
  logic cout_a, gt_a, lt_a, eq_a, cout_b, gt_b, lt_b, eq_b;
  int checks = 0, failures = 0;
  localparam logic [13:0] C_ADD = 14'h1, C_AND = 14'h40, C_ANDB = 14'h8, C_NOTB = 14'h20,
                          C_CIN = 14'h80, C_CMPL = 14'h100, C_CMP = 14'h400, C_SHL = 14'h800;

  rns_int_alu #(.MODULUS(9'd129)) dut (
    .clk(clk), .reset(reset), .alu_en(alu_en), .rns_en(rns_en), .op1_in(op1), .op2_in(op2),
    .alu_ctrl(ctrl), .mul_op(mul_op), .dout(dout_a), .cout(cout_a), .comp_gt(gt_a),
    .comp_lt(lt_a), .comp_eq(eq_a), .rns_dout(rns_a));
  rns_int_alu #(.MODULUS(9'd256)) dut256 (
    .clk(clk), .reset(reset), .alu_en(alu_en), .rns_en(rns_en), .op1_in(op1), .op2_in(op2),
    .alu_ctrl(ctrl), .mul_op(mul_op), .dout(dout_b), .cout(cout_b), .comp_gt(gt_b),
    .comp_lt(lt_b), .comp_eq(eq_b), .rns_dout(rns_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit ae, input bit re, input logic [13:0] c, input int a, input int b, input bit m);
    alu_en = ae; rns_en = re; ctrl = c; op1 = 8'(a); op2 = 8'(b); mul_op = m;
    @(posedge clk); #1;
  endtask

  function automatic void alu_model(output int d, output int c, output int g, output int l, output int e);
    int a, b, s;
    a = op1; b = op2; d = 0; c = 0; g = 0; l = 0; e = 0;
    if (!alu_en) return;
    if (ctrl[10]) begin
      d = (a - b + 256) % 256; c = (a >= b); g = (a > b); l = (a < b); e = (a == b);
    end else if (ctrl[0]) begin
      s = a + (ctrl[8] ? 255 - b : b) + int'(ctrl[7]);
      d = s % 256; c = s / 256;
    end else if (ctrl[11]) begin
      d = (a * 2) % 256; c = a / 128;
    end else if (ctrl[6]) d = (a != 0 && b != 0);
    else if (ctrl[1]) d = (a != 0 || b != 0);
    else if (ctrl[2]) d = (a == 0);
    else if (ctrl[3]) d = a & b;
    else if (ctrl[4]) d = a | b;
    else if (ctrl[5]) d = 255 - a;
  endfunction

  function automatic int rns_model(input int m);
    int x, y;
    x = op1 % m; y = op2 % m;
    if (!rns_en) return 0;
    if (mul_op) return (x * y) % m;
    if (ctrl[0] && ctrl[8]) return (x - y + m) % m;
    if (ctrl[0]) return (x + y) % m;
    return 0;
  endfunction

  task automatic check_model(input string tag);
    int d, c, g, l, e;
    alu_model(d, c, g, l, e);
    chk({tag, ".dout"}, dout_a, d);
    chk({tag, ".cout"}, cout_a, c);
    chk({tag, ".flags"}, {gt_a, lt_a, eq_a}, g * 4 + l * 2 + e);
    chk({tag, ".dout256"}, dout_b, d);
    chk({tag, ".rns129"}, rns_a, rns_model(129));
    chk({tag, ".rns256"}, rns_b, rns_model(256));
  endtask

  initial begin
    logic [13:0] c;
    int a, b;
    #12;
    chk("rst.dout", dout_a, 0);
    chk("rst.rns", rns_a, 0);
    reset = 1;
    drive(1, 0, C_ADD, 1, 1, 0);
    chk("add1+1", dout_a, 2);
    #2 reset = 0; #1;
    chk("async.dout", dout_a, 0);
    chk("async.all", {cout_a, gt_a, lt_a, eq_a, rns_a}, 0);
    @(posedge clk); #1;
    chk("held.dout", dout_a, 0);
    #2 reset = 1;
    drive(1, 0, C_ADD, 3, 4, 0);
    chk("add3+4", {cout_a, dout_a}, 7);
    drive(1, 0, C_ADD, 200, 100, 0);
    chk("add200+100", {cout_a, dout_a}, 256 + 44);
    drive(1, 0, C_ADD | C_CMPL | C_CIN, 5, 10, 0);
    chk("sub5-10", {cout_a, dout_a}, 251);
    drive(1, 0, C_CMP, 5, 9, 0);
    chk("cmp5,9.flags", {gt_a, lt_a, eq_a}, 3'b010);
    chk("cmp5,9.dout", dout_a, 252);
    drive(1, 0, C_CMP, 9, 9, 0);
    chk("cmp9,9", {eq_a, cout_a, dout_a}, 10'b11_0000_0000);
    drive(1, 0, C_SHL, 8'h81, 0, 0);
    chk("shl81", {cout_a, dout_a}, 9'h102);
    drive(1, 0, C_ANDB, 8'hF0, 8'h3C, 0);
    chk("andb", dout_a, 8'h30);
    drive(1, 0, C_AND, 0, 7, 0);
    chk("land0,7", dout_a, 0);
    drive(1, 0, C_NOTB, 8'h0F, 0, 0);
    chk("notb", dout_a, 8'hF0);
    drive(0, 1, C_ADD, 100, 50, 0);
    chk("rns.add", rns_a, 21);
    drive(0, 1, C_ADD | C_CMPL, 5, 10, 0);
    chk("rns.sub", rns_a, 124);
    drive(0, 1, 0, 20, 10, 1);
    chk("rns.mul", rns_a, 71);
    drive(0, 1, C_ADD, 200, 0, 0);
    chk("rns.red", rns_a, 71);
    drive(0, 0, C_ADD, 200, 0, 0);
    chk("rns.off", rns_a, 0);
    drive(0, 1, C_ADD, 16, 17, 1);
    chk("rns256.mul", rns_b, 16);
    chk("rns256.alu_off", {dout_b, cout_b, gt_b, lt_b, eq_b}, 0);
    for (int i = 0; i < 300; i++) begin
      c = ($urandom_range(0, 1) == 1) ? 14'(1 << $urandom_range(0, 11)) : 14'($urandom & 14'h1fff);
      c = c | 14'($urandom & 14'h180);
      a = (i % 7 == 0) ? 0 : (i % 11 == 0) ? 255 : int'($urandom_range(0, 255));
      b = (i % 5 == 0) ? a : (i % 13 == 0) ? 0 : int'($urandom_range(0, 255));
      drive(1'($urandom), 1'($urandom), c, a, b, 1'($urandom_range(0, 3) == 0));
      check_model("rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
